// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw button/switch inputs and conditioned outputs bundle
interface input_conditioner_if #(
    parameter int SW_WIDTH = 16
);
    logic                ssl_raw;
    logic [SW_WIDTH-1:0] sw_raw;
    logic                ssl_pulse;
    logic                ssl_level;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [SW_WIDTH-1:0] sw_snap;

    modport master (
        output ssl_raw,
        output sw_raw,
        input  ssl_pulse,
        input  ssl_level,
        input  sw_sync,
        input  sw_snap
    );

    modport slave (
        input  ssl_raw,
        input  sw_raw,
        output ssl_pulse,
        output ssl_level,
        output sw_sync,
        output sw_snap
    );
endinterface

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise switches, debounce confirm button, snapshot switches on press
module input_conditioner #(
    parameter int SW_WIDTH        = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic               clock,
    input logic               reset,
    input_conditioner_if.slave io
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0]               ssl_sync_q, ssl_sync_d;
    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 ssl_pulse_q, ssl_pulse_d;
    logic                                 ssl_level_q, ssl_level_d;
    logic [SW_WIDTH-1:0]                  sw_snap_q, sw_snap_d;

    logic                ssl_s;
    logic [SW_WIDTH-1:0] sw_s;

    assign ssl_s = ssl_sync_q[SYNC_STAGES-1];
    assign sw_s  = sw_sync_q[SYNC_STAGES-1];

    always_comb begin
        ssl_sync_d    = ssl_sync_q << 1;
        ssl_sync_d[0] = io.ssl_raw;
        sw_sync_d     = sw_sync_q;
        sw_sync_d[0]  = io.sw_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync_d[i] = sw_sync_q[i-1];
        end
    end

    // cnt tracks consecutive samples disagreeing with the debounced level
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ssl_pulse_d = 1'b0;
        sw_snap_d   = sw_snap_q;
        case (state_q)
            IDLE: begin
                if (ssl_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!ssl_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    ssl_pulse_d = 1'b1;
                    sw_snap_d   = sw_s;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!ssl_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (ssl_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ssl_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ssl_sync_q  <= '0;
            sw_sync_q   <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            ssl_pulse_q <= 1'b0;
            ssl_level_q <= 1'b0;
            sw_snap_q   <= '0;
        end else begin
            ssl_sync_q  <= ssl_sync_d;
            sw_sync_q   <= sw_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ssl_pulse_q <= ssl_pulse_d;
            ssl_level_q <= ssl_level_d;
            sw_snap_q   <= sw_snap_d;
        end
    end

    assign io.ssl_pulse = ssl_pulse_q;
    assign io.ssl_level = ssl_level_q;
    assign io.sw_sync   = sw_s;
    assign io.sw_snap   = sw_snap_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and random checks of input_conditioner against a run-length model
module tb_input_conditioner;
    localparam int SW   = 16;
    localparam int SYNC = 2;
    localparam int DEB  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    input_conditioner_if #(.SW_WIDTH(SW)) ifc ();

    input_conditioner #(
        .SW_WIDTH       (SW),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (ifc)
    );

    always #5 clock = ~clock;

    // Model: level flips after DEB consecutive synchronised samples disagreeing with it
    logic          m_ssl_pipe [SYNC];
    logic [SW-1:0] m_sw_pipe  [SYNC];
    logic          m_level;
    logic          m_pulse;
    logic [SW-1:0] m_snap;
    int            m_run;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SYNC; i++) begin
            m_ssl_pipe[i] = 1'b0;
            m_sw_pipe[i]  = '0;
        end
        m_level = 1'b0;
        m_pulse = 1'b0;
        m_snap  = '0;
        m_run   = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_pulse"}, SW'(ifc.ssl_pulse), SW'(m_pulse));
        chk({tag, "_level"}, SW'(ifc.ssl_level), SW'(m_level));
        chk({tag, "_sync"},  ifc.sw_sync, m_sw_pipe[SYNC-1]);
        chk({tag, "_snap"},  ifc.sw_snap, m_snap);
    endtask

    task automatic step(input string tag);
        logic          s_pre;
        logic [SW-1:0] sw_pre;
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            s_pre   = m_ssl_pipe[SYNC-1];
            sw_pre  = m_sw_pipe[SYNC-1];
            m_pulse = 1'b0;
            if (s_pre != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = s_pre;
                    m_run   = 0;
                    if (s_pre) begin
                        m_pulse = 1'b1;
                        m_snap  = sw_pre;
                    end
                end
            end else begin
                m_run = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) begin
                m_ssl_pipe[i] = m_ssl_pipe[i-1];
                m_sw_pipe[i]  = m_sw_pipe[i-1];
            end
            m_ssl_pipe[0] = ifc.ssl_raw;
            m_sw_pipe[0]  = ifc.sw_raw;
        end
        #1;
        compare_all(tag);
    endtask

    task automatic assert_reset(input string tag);
        reset = 1'b1;
        model_clear();
        #1;
        chk({tag, "_async_pulse"}, SW'(ifc.ssl_pulse), '0);
        chk({tag, "_async_level"}, SW'(ifc.ssl_level), '0);
        chk({tag, "_async_sync"},  ifc.sw_sync, '0);
        chk({tag, "_async_snap"},  ifc.sw_snap, '0);
    endtask

    initial begin
        int pcount;
        int pcyc;
        int lcyc;
        int lvl_cnt;

        ifc.ssl_raw = 1'b0;
        ifc.sw_raw  = '0;
        model_clear();

        // reset state
        repeat (3) step("rst_hold");
        reset = 1'b0;
        repeat (3) step("idle");

        // press with switches A5C3: pulse in cycle 10, held 40 cycles with no repeat
        ifc.sw_raw  = 16'hA5C3;
        ifc.ssl_raw = 1'b1;
        pcount = 0; pcyc = 0; lcyc = 0;
        for (int k = 1; k <= 40; k++) begin
            step("t2");
            if (ifc.ssl_pulse) begin pcount++; pcyc = k; end
            if (ifc.ssl_level && lcyc == 0) lcyc = k;
        end
        chk("t2_pulse_cycle", SW'(pcyc), SW'(10));
        chk("t2_pulse_count", SW'(pcount), SW'(1));
        chk("t2_level_cycle", SW'(lcyc), SW'(10));
        chk("t2_snap", ifc.sw_snap, 16'hA5C3);

        // switch change while pressed
        ifc.sw_raw = 16'h0F0F;
        step("t6");
        chk("t6_sync_1", ifc.sw_sync, 16'hA5C3);
        step("t6");
        chk("t6_sync_2", ifc.sw_sync, 16'h0F0F);
        chk("t6_snap", ifc.sw_snap, 16'hA5C3);

        // release bounce: low 3, high 2, low held
        pcount = 0; lcyc = 0;
        ifc.ssl_raw = 1'b0;
        repeat (3) begin step("t4"); if (ifc.ssl_pulse) pcount++; end
        ifc.ssl_raw = 1'b1;
        repeat (2) begin step("t4"); if (ifc.ssl_pulse) pcount++; end
        ifc.ssl_raw = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step("t4");
            if (ifc.ssl_pulse) pcount++;
            if (!ifc.ssl_level && lcyc == 0) lcyc = k;
        end
        chk("t4_pulse_count", SW'(pcount), SW'(0));
        chk("t4_fall_cycle", SW'(lcyc), SW'(10));

        // short glitch rejected
        pcount = 0; lvl_cnt = 0;
        ifc.ssl_raw = 1'b1;
        repeat (5) begin step("t3"); if (ifc.ssl_pulse) pcount++; if (ifc.ssl_level) lvl_cnt++; end
        ifc.ssl_raw = 1'b0;
        repeat (20) begin step("t3"); if (ifc.ssl_pulse) pcount++; if (ifc.ssl_level) lvl_cnt++; end
        chk("t3_pulse_count", SW'(pcount), SW'(0));
        chk("t3_level_cycles", SW'(lvl_cnt), SW'(0));

        // async reset while all outputs are nonzero
        ifc.ssl_raw = 1'b1;
        ifc.sw_raw  = 16'h3C3C;
        repeat (10) step("t1");
        chk("t1_pre_pulse", SW'(ifc.ssl_pulse), SW'(1));
        chk("t1_pre_snap", ifc.sw_snap, 16'h3C3C);
        ifc.ssl_raw = 1'b0;
        assert_reset("t1");
        repeat (2) step("t1_rst");
        reset = 1'b0;
        pcount = 0;
        repeat (15) begin step("t1_post"); if (ifc.ssl_pulse || ifc.ssl_level) pcount++; end
        chk("t1_post_quiet", SW'(pcount), SW'(0));

        // reset during PRESS_WAIT with button held through reset
        ifc.ssl_raw = 1'b1;
        repeat (5) step("t5");
        assert_reset("t5");
        pcount = 0;
        repeat (2) begin step("t5_rst"); if (ifc.ssl_pulse) pcount++; end
        reset = 1'b0;
        pcyc = 0;
        for (int k = 1; k <= 20; k++) begin
            step("t5_post");
            if (ifc.ssl_pulse) begin pcount++; pcyc = k; end
        end
        chk("t5_pulse_cycle", SW'(pcyc), SW'(10));
        chk("t5_pulse_count", SW'(pcount), SW'(1));
        ifc.ssl_raw = 1'b0;
        repeat (12) step("t5_rel");

        // random bouncy button, switches and occasional resets
        for (int e = 0; e < 200; e++) begin
            ifc.ssl_raw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) ifc.sw_raw = SW'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                assert_reset("rnd");
                repeat ($urandom_range(1, 3)) step("rnd_rst");
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 14)) begin
                if ($urandom_range(0, 9) == 0) ifc.sw_raw = SW'($urandom);
                step("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
